// File: rtl/c_table_bank_pkg.sv
// Shared FM-index definitions: symbol encodings, default alphabet size, table state.
package fm_pkg;
  localparam int         SYM_W_DEF = 2;
  localparam int         NSYM      = 1 << SYM_W_DEF;
  localparam logic [1:0] SYM_A     = 2'b00;
  localparam logic [1:0] SYM_C     = 2'b01;
  localparam logic [1:0] SYM_G     = 2'b10;
  localparam logic [1:0] SYM_T     = 2'b11;

  typedef enum logic [1:0] {EMPTY, LOADING, READY} tbl_state_t;

  function automatic int nsym(input int sym_w);
    return 1 << sym_w;
  endfunction
endpackage

// File: rtl/c_table_bank_if.sv
// Load handshake, status and multi-channel lookup bus of the C-table bank.
interface c_table_bank_if #(
  parameter int SYM_W  = 2,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2
);
  logic                     clear;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [DATA_W-1:0]        ld_count;
  logic                     tbl_rdy;
  logic [DATA_W-1:0]        total;
  logic                     ovf;
  logic [NUM_CH-1:0]        rd_en;
  logic [NUM_CH*SYM_W-1:0]  rd_sym;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0]        rd_vld;
  logic [NUM_CH-1:0]        rd_err;

  modport master (
    output clear, ld_valid, ld_count, rd_en, rd_sym,
    input  ld_ready, tbl_rdy, total, ovf, rd_data, rd_vld, rd_err
  );
  modport slave (
    input  clear, ld_valid, ld_count, rd_en, rd_sym,
    output ld_ready, tbl_rdy, total, ovf, rd_data, rd_vld, rd_err
  );
endinterface

// File: rtl/c_table_read_port.sv
// One registered C-table lookup channel; answers zero with err when the table is not ready.
module c_table_read_port
  import fm_pkg::*;
#(
  parameter int SYM_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                ready,
  input  logic [SYM_W-1:0]                    sym,
  input  logic [nsym(SYM_W)-1:0][DATA_W-1:0]  entry,
  output logic [DATA_W-1:0]                   data,
  output logic                                vld,
  output logic                                err
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      vld  <= 1'b0;
      err  <= 1'b0;
    end else begin
      vld  <= en;
      err  <= en & ~ready;
      data <= (en & ready) ? entry[sym] : '0;
    end
  end
endmodule

// File: rtl/c_table_bank.sv
// Run-time loadable C-array for FM-index backward search: prefix-sum build plus NUM_CH lookup ports.
module c_table_bank
  import fm_pkg::*;
#(
  parameter int SYM_W    = 2,
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int C_OFFSET = 1
) (
  input  logic           clk,
  input  logic           rst,
  c_table_bank_if.slave  bus
);
  localparam int NS    = nsym(SYM_W);
  localparam int IDX_W = (SYM_W > 0) ? SYM_W : 1;

  tbl_state_t                  state, state_nx;
  logic [NS-1:0][DATA_W-1:0]   entry;
  logic [IDX_W-1:0]            idx;
  logic [DATA_W-1:0]           acc, total;
  logic                        ovf, tbl_rdy, accept, last, is_rdy;
  logic [DATA_W:0]             acc_sum, tot_sum;

  assign is_rdy       = (state == READY);
  assign bus.ld_ready = ~is_rdy & ~bus.clear;
  assign accept       = bus.ld_valid & bus.ld_ready;
  assign last         = (idx == IDX_W'(NS - 1));
  assign acc_sum      = {1'b0, acc}   + {1'b0, bus.ld_count};
  assign tot_sum      = {1'b0, total} + {1'b0, bus.ld_count};
  assign bus.tbl_rdy  = tbl_rdy;
  assign bus.total    = total;
  assign bus.ovf      = ovf;

  always_comb begin
    state_nx = state;
    if (bus.clear)  state_nx = EMPTY;
    else if (accept) state_nx = last ? READY : LOADING;
  end

  // acc is the running C value, so it always restarts at the sentinel offset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      tbl_rdy <= 1'b0;
      entry   <= '0;
      idx     <= '0;
      acc     <= DATA_W'(C_OFFSET);
      total   <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      tbl_rdy <= (state_nx == READY);
      if (bus.clear) begin
        idx   <= '0;
        acc   <= DATA_W'(C_OFFSET);
        total <= '0;
        ovf   <= 1'b0;
      end else if (accept) begin
        entry[idx] <= acc;
        acc        <= acc_sum[DATA_W-1:0];
        total      <= tot_sum[DATA_W-1:0];
        idx        <= idx + IDX_W'(1);
        ovf        <= ovf | acc_sum[DATA_W] | tot_sum[DATA_W];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    c_table_read_port #(.SYM_W(SYM_W), .DATA_W(DATA_W)) u_rp (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.rd_en[i]),
      .ready (is_rdy),
      .sym   (bus.rd_sym[i*SYM_W +: SYM_W]),
      .entry (entry),
      .data  (bus.rd_data[i*DATA_W +: DATA_W]),
      .vld   (bus.rd_vld[i]),
      .err   (bus.rd_err[i])
    );
  end
endmodule
